uart_rx: RTL and testbench
==========================

# uart_rx

Receive-side counterpart of the 11-bit UART transmitter in the serial path. The block oversamples the incoming serial line with the same baud divider the transmitter uses. It locates each frame's start bit, samples all 11 frame bits at bit centre, and checks the marker and parity bits. It then presents the recovered byte with a one-cycle valid strobe and error flags to downstream logic.

## Interface
Parameters:
- CLKS_PER_BIT, 21, clock cycles per serial bit; must equal the transmitter divider period (terminal count 20, plus 1).
- HALF_BIT, 10, cycles from start-bit detection to start-bit centre; equals CLKS_PER_BIT/2, rounded down.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  reset, synchronous, active-high.
- rx_in  in  1  serial line; asynchronous to clk; idles high.
- data_out  out  8  last received byte; reset 8'h00; updated only in the valid cycle.
- valid  out  1  one-cycle pulse, one per completed frame; reset 0.
- parity_err  out  1  frame bit 10 != ^data; reset 0; updated in the valid cycle, held until the next valid.
- frame_err  out  1  frame bit 9 != 1; reset 0; updated and held like parity_err.
- busy  out  1  high in every state except IDLE; reset 0.

## Operation
- Frame order on the line, index 0 first:
  - index 0: start bit (0)
  - indices 1..8: data[0..7], LSB first
  - index 9: marker bit (1)
  - index 10: parity bit, equal to the XOR of the 8 data bits
- rx_in passes through a 2-flop synchronizer. Both flops reset to 1. All logic below uses the synchronizer output rxs.
- State machine (4 states):
  - IDLE: if rxs==0, go to START and clear the baud counter.
  - START: when the baud counter reaches HALF_BIT-1, sample rxs.
    - rxs==1: false start; go to IDLE with no outputs.
    - rxs==0: go to DATA with bit index = 1 and baud counter cleared.
  - DATA: when the baud counter reaches CLKS_PER_BIT-1, sample rxs into shift position [bit index], then increment the index. After sampling index 10, go to WAIT_HIGH and assert valid and the error flags on the next edge.
  - WAIT_HIGH: stay until rxs==1, then go to IDLE. This prevents a 0 parity bit, or a stuck-low line, from being taken as a new start bit.
- Baud counter: 5 bits, counts 0..CLKS_PER_BIT-1. Clears at terminal count and on every state entry. Does not advance in IDLE or WAIT_HIGH.
- Bit index: 4 bits, range 1..10. It never wraps.
- valid fires even when frame_err or parity_err is set. data_out is loaded regardless of the error flags.

## Timing
- L = first clk edge at which rxs is 0 in IDLE. L = line falling edge + 2 cycles (+1 for asynchronous phase).
- Start-bit centre is sampled at L+HALF_BIT (L+10).
- Bit k (k = 1..10) is sampled at L+10+21k. Bit 10 is sampled at L+220.
- valid, data_out, parity_err and frame_err are registered at L+221.
- Back-to-back frames: the transmitter holds the line high for at least 1 cycle between frames. WAIT_HIGH accepts a 1-cycle high pulse, so no frame may be dropped.
- rst at any cycle (including mid-frame): on the next edge, return to IDLE, set all outputs to reset values, and reset the synchronizer to 1. No partial valid is produced.
- rst has priority over every state transition and over the valid pulse.

## Structure
- Shared package/header uart_pkg holds:
  - FRAME_BITS=11, DATA_BITS=8
  - MARKER_IDX=9, PARITY_IDX=10
  - default CLKS_PER_BIT=21
  - the 2-bit state encoding: IDLE=0, START=1, DATA=2, WAIT_HIGH=3
- One sub-module, uart_rx_baud_cnt. It holds the baud counter with clear, enable and a terminal/half compare. It outputs the tick signals mid_tick and bit_tick.
- The synchronizer, FSM, bit index, shift register and error checks live in uart_rx itself.

## Test plan
- Send 0xA5 (line 0,1,0,1,0,0,1,0,1,1,0) -> one valid at L+221, data_out=8'hA5, parity_err=0, frame_err=0.
- Send 0x01 with bit 10 forced to 0 -> data_out=8'h01, parity_err=1, frame_err=0.
- Send 0x3C with bit 9 forced to 0 -> data_out=8'h3C, frame_err=1, parity_err=0.
- 5-cycle low glitch on an idle line -> false start, no valid, busy returns to 0 by L+11.
- Frames 0x00 then 0xFF with a 1-cycle high gap between them -> two valids 232 cycles apart (231 cycles per frame + 1 gap), data 8'h00 then 8'hFF, no errors.
- rst pulsed at L+100 during 0x5A, then a clean 0x5A -> no valid from the aborted frame, one valid with 8'h5A from the second frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 11-bit UART serial path.
// Holds the frame geometry, default baud divider period, counter widths,
// the receiver FSM state encoding and a byte parity helper.
package uart_pkg;

  localparam int unsigned FRAME_BITS           = 11;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned MARKER_IDX           = 9;
  localparam int unsigned PARITY_IDX           = 10;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 21;

  // Baud counter spans 0..CLKS_PER_BIT-1; bit index spans 1..10.
  localparam int unsigned CNT_W = 5;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    DATA      = 2'd2,
    WAIT_HIGH = 2'd3
  } state_e;

  // Even parity of a data byte (XOR of all bits).
  function automatic logic parity8(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_baud_cnt.sv
// Baud-rate counter for the UART receiver.
// Counts 0..CLKS_PER_BIT-1 while enabled, wrapping at terminal count.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   clr_i      synchronous clear (has priority over enable)
//   en_i       count enable
//   mid_tick_o counter == HALF_BIT-1 (start-bit centre)
//   bit_tick_o counter == CLKS_PER_BIT-1 (bit centre / terminal count)
module uart_rx_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic mid_tick_o,
  output logic bit_tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign mid_tick_o = (cnt_q == CNT_W'(HALF_BIT - 1));
  assign bit_tick_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = bit_tick_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver for the 11-bit frame: start(0), 8 data bits LSB first,
// marker(1), even parity. Oversamples the line with the transmitter's baud
// divider, samples every bit at its centre and reports the byte with a
// one-cycle valid strobe plus marker/parity error flags.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx_in      asynchronous serial line, idles high
//   data_out   last received byte (updated in the valid cycle)
//   valid      one-cycle pulse per completed frame
//   parity_err parity bit != XOR of data, held until next valid
//   frame_err  marker bit != 1, held until next valid
//   busy       receiver not in IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  // Two-flop synchronizer, reset to the idle level.
  logic sync1_q, rxs_q;

  state_e state_q, state_d;

  logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:1]   frame_q, frame_d;
  logic                    done_q, done_d;

  logic [DATA_BITS-1:0]    data_q;
  logic                    valid_q, perr_q, ferr_q;

  logic cnt_clr, cnt_en, mid_tick, bit_tick;
  logic last_bit;

  uart_rx_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .HALF_BIT     (HALF_BIT)
  ) u_baud_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .mid_tick_o (mid_tick),
    .bit_tick_o (bit_tick)
  );

  assign last_bit = (bit_idx_q == IDX_W'(PARITY_IDX));

  // Counter restarts on every state change and only runs while timing bits.
  assign cnt_clr = (state_d != state_q);
  assign cnt_en  = (state_q == START) || (state_q == DATA);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!rxs_q) state_d = START;
      START:     if (mid_tick) state_d = rxs_q ? IDLE : DATA;
      DATA:      if (bit_tick && last_bit) state_d = WAIT_HIGH;
      WAIT_HIGH: if (rxs_q) state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    if (state_q == START && mid_tick && !rxs_q) begin
      bit_idx_d = IDX_W'(1);
    end else if (state_q == DATA && bit_tick) begin
      for (int unsigned i = 1; i < FRAME_BITS; i++) begin
        if (bit_idx_q == IDX_W'(i)) frame_d[i] = rxs_q;
      end
      if (last_bit) begin
        done_d = 1'b1;
      end else begin
        bit_idx_d = bit_idx_q + IDX_W'(1);
      end
    end
  end

  // Results are published one edge after the parity bit is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= IDLE;
      bit_idx_q <= IDX_W'(1);
      frame_q   <= '0;
      done_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= rx_in;
      rxs_q     <= sync1_q;
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
      valid_q   <= done_q;
      if (done_q) begin
        data_q <= frame_q[DATA_BITS:1];
        perr_q <= frame_q[PARITY_IDX] != parity8(frame_q[DATA_BITS:1]);
        ferr_q <= !frame_q[MARKER_IDX];
      end
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx.
// Cycle numbering: a line change driven just after posedge P is first seen
// by the clock at P+1, reaches the FSM at L=P+3, and valid is registered at
// L+221 = P+224.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       valid, parity_err, frame_err, busy;

  uart_rx #(
    .CLKS_PER_BIT (21),
    .HALF_BIT     (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         v_cyc[$];
  logic [7:0] v_data[$];
  logic       v_perr[$];
  logic       v_ferr[$];

  always @(negedge clk) begin
    if (valid) begin
      v_cyc.push_back(cyc);
      v_data.push_back(data_out);
      v_perr.push_back(parity_err);
      v_ferr.push_back(frame_err);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_q();
    v_cyc.delete();
    v_data.delete();
    v_perr.delete();
    v_ferr.delete();
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic bad_par,
                                     input logic bad_mark);
    return {(^d) ^ bad_par, ~bad_mark, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [10:0] bits, output int start);
    @(posedge clk);
    #1;
    start = cyc;
    rx_in = bits[0];
    for (int i = 1; i < 11; i++) begin
      repeat (21) @(posedge clk);
      #1 rx_in = bits[i];
    end
    repeat (21) @(posedge clk);
    #1 rx_in = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_mark;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int st, s0, s1;
    logic [10:0] bits;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0};
    vecs[4] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // Single frames from the table
    foreach (vecs[k]) begin
      clear_q();
      send_frame(mk(vecs[k].data, vecs[k].bad_par, vecs[k].bad_mark), st);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_nvalid", k), v_cyc.size(), 1);
      if (v_cyc.size() >= 1) begin
        chk($sformatf("v%0d_latency", k), v_cyc[0] - st, 224);
        chk($sformatf("v%0d_data", k), v_data[0], vecs[k].exp_data);
        chk($sformatf("v%0d_perr", k), v_perr[0], vecs[k].exp_perr);
        chk($sformatf("v%0d_ferr", k), v_ferr[0], vecs[k].exp_ferr);
      end
      chk($sformatf("v%0d_idle_busy", k), busy, 0);
    end

    // 5-cycle low glitch: false start, back to IDLE after L+10
    clear_q();
    @(posedge clk);
    #1;
    st = cyc;
    rx_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx_in = 1'b1;
    @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    repeat (250) @(posedge clk);
    chk("glitch_nvalid", v_cyc.size(), 0);

    // Back-to-back frames with a 1-cycle high gap
    clear_q();
    send_frame(mk(8'h00, 1'b0, 1'b0), s0);
    send_frame(mk(8'hFF, 1'b0, 1'b0), s1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("b2b_nvalid", v_cyc.size(), 2);
    if (v_cyc.size() >= 2) begin
      chk("b2b_lat0", v_cyc[0] - s0, 224);
      chk("b2b_spacing", v_cyc[1] - v_cyc[0], 232);
      chk("b2b_data0", v_data[0], 8'h00);
      chk("b2b_data1", v_data[1], 8'hFF);
      chk("b2b_err0", {v_perr[0], v_ferr[0]}, 0);
      chk("b2b_err1", {v_perr[1], v_ferr[1]}, 0);
    end

    // Reset at L+100 mid-frame; the transmitter idles the line too
    clear_q();
    bits = mk(8'h5A, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    st = cyc;
    rx_in = bits[0];
    for (int i = 1; i < 5; i++) begin
      repeat (21) @(posedge clk);
      #1 rx_in = bits[i];
    end
    repeat (18) @(posedge clk);
    #1;
    rst = 1'b1;
    rx_in = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_data", data_out, 0);
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_errs", {parity_err, frame_err}, 0);
    repeat (300) @(posedge clk);
    chk("abort_nvalid", v_cyc.size(), 0);

    clear_q();
    send_frame(mk(8'h5A, 1'b0, 1'b0), st);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_rst_nvalid", v_cyc.size(), 1);
    if (v_cyc.size() >= 1) begin
      chk("post_rst_latency", v_cyc[0] - st, 224);
      chk("post_rst_data", v_data[0], 8'h5A);
      chk("post_rst_errs", {v_perr[0], v_ferr[0]}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
